// File: rtl/sync_debounce.sv
// Multi-channel input conditioner for push buttons and switches.
// Each channel has its own synchroniser and debounce filter, and outputs a level plus rise/fall pulses.
module sync_debounce #(
   parameter int CHANNELS        = 4,
   parameter int STAGES          = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] d,
   input  logic                tick,
   output logic [CHANNELS-1:0] q,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [STAGES-1:0] sync_r;
      logic [CW-1:0]     cnt;
      logic              q_r;
      logic              rise_r;
      logic              fall_r;
      logic              s;

      assign s = sync_r[STAGES-1];

      // The level only flips once s has disagreed with it for DEBOUNCE_CYCLES consecutive ticks;
      // any agreement in between restarts the run.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_r <= '0;
            cnt    <= '0;
            q_r    <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
         end else begin
            sync_r <= {sync_r[STAGES-2:0], d[i]};
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            if (s == q_r) begin
               cnt <= '0;
            end else if (tick) begin
               if (cnt == CNT_LAST) begin
                  q_r    <= s;
                  cnt    <= '0;
                  rise_r <= s;
                  fall_r <= ~s;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         end
      end

      assign q[i]    = q_r;
      assign rise[i] = rise_r;
      assign fall[i] = fall_r;
   end

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce: directed scenarios plus randomized inputs,
// checked cycle by cycle against a behavioural model of delayed input and run lengths.
module tb_sync_debounce;

   localparam int CH = 4;
   localparam int ST = 2;
   localparam int DC = 4;

   typedef struct {
      logic [CH-1:0] q;
      logic [CH-1:0] rise;
      logic [CH-1:0] fall;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] d;
   logic          tick;
   logic [CH-1:0] q;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;

   int checks = 0;
   int passes = 0;

   exp_t          sb[$];
   exp_t          monExp;
   logic [CH-1:0] hist[$];
   logic [CH-1:0] mq;
   logic [CH-1:0] mr;
   logic [CH-1:0] mf;
   int            run[CH];

   sync_debounce #(.CHANNELS(CH), .STAGES(ST), .DEBOUNCE_CYCLES(DC)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (d),
      .tick (tick),
      .q    (q),
      .rise (rise),
      .fall (fall)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name,
                              input logic [CH-1:0] aq, input logic [CH-1:0] ar, input logic [CH-1:0] af,
                              input logic [CH-1:0] eq, input logic [CH-1:0] er, input logic [CH-1:0] ef);
      checks++;
      if (aq === eq && ar === er && af === ef) passes++;
      else $display("[TB] FAIL %s @%0t: got q=%b rise=%b fall=%b, expected q=%b rise=%b fall=%b",
                    name, $time, aq, ar, af, eq, er, ef);
   endtask

   task automatic checkValue(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Model: s is the input sampled ST edges earlier; q follows s after DC consecutive ticks of disagreement.
   task automatic modelStep(input logic [CH-1:0] dv, input logic t, input logic r);
      logic [CH-1:0] s;
      exp_t e;
      mr = '0;
      mf = '0;
      if (!r) begin
         hist.delete();
         for (int k = 0; k < ST; k++) hist.push_back('0);
         mq = '0;
         for (int c = 0; c < CH; c++) run[c] = 0;
      end else begin
         s = hist.pop_front();
         hist.push_back(dv);
         for (int c = 0; c < CH; c++) begin
            if (s[c] == mq[c]) run[c] = 0;
            else if (t) begin
               run[c]++;
               if (run[c] == DC) begin
                  mq[c]  = s[c];
                  run[c] = 0;
                  if (s[c]) mr[c] = 1'b1;
                  else      mf[c] = 1'b1;
               end
            end
         end
      end
      e.q    = mq;
      e.rise = mr;
      e.fall = mf;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input logic [CH-1:0] dv, input logic t, input logic r);
      @(negedge clk);
      #1;
      d     = dv;
      tick  = t;
      rst_n = r;
      modelStep(dv, t, r);
      if (!r) begin
         #1;
         checkOutput("async_reset", q, rise, fall, '0, '0, '0);
      end
   endtask

   task automatic measureRise(input string name, input logic [CH-1:0] dv, input int ch);
      int got;
      got = -1;
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(dv, 1'b1, 1'b1);
         @(posedge clk);
         #1;
         if (q[ch]) begin
            got = k;
            break;
         end
      end
      checkValue(name, got, ST + DC);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         monExp = sb.pop_front();
         checkOutput("cycle", q, rise, fall, monExp.q, monExp.rise, monExp.fall);
      end
   end

   initial begin
      logic [CH-1:0] cur;
      logic          tk;
      mq = '0;
      mr = '0;
      mf = '0;
      for (int k = 0; k < ST; k++) hist.push_back('0);
      for (int c = 0; c < CH; c++) run[c] = 0;

      rst_n = 1'b0;
      d     = 4'hF;
      tick  = 1'b1;
      #1;
      checkOutput("reset_initial", q, rise, fall, '0, '0, '0);
      repeat (3) applyStimulus(4'hF, 1'b1, 1'b0);
      repeat (20) applyStimulus(4'h0, 1'b1, 1'b1);

      // Rising edge latency on channel 0
      measureRise("latency_rise_ch0", 4'b0001, 0);
      repeat (4) applyStimulus(4'b0001, 1'b1, 1'b1);

      // Glitches on channel 1 that must be rejected, then an accepted pulse
      repeat (3) applyStimulus(4'b0011, 1'b1, 1'b1);
      repeat (2) applyStimulus(4'b0001, 1'b1, 1'b1);
      repeat (3) applyStimulus(4'b0011, 1'b1, 1'b1);
      repeat (2) applyStimulus(4'b0001, 1'b1, 1'b1);
      repeat (8) applyStimulus(4'b0011, 1'b1, 1'b1);

      // Tick one cycle in four on channel 2
      for (int k = 0; k < 28; k++) applyStimulus(4'b0111, (k % 4) == 3, 1'b1);

      // Simultaneous opposite edges on channels 2 and 3
      repeat (10) applyStimulus(4'b1000, 1'b1, 1'b1);
      repeat (10) applyStimulus(4'b0100, 1'b1, 1'b1);

      // Reset in the middle of a count
      repeat (6) applyStimulus(4'b0000, 1'b1, 1'b1);
      repeat (3) applyStimulus(4'b0001, 1'b1, 1'b1);
      applyStimulus(4'b0001, 1'b1, 1'b0);
      measureRise("latency_after_reset", 4'b0001, 0);

      // Randomized channel activity with occasional resets
      cur = 4'b0001;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
         tk = (n < 1500) ? 1'b1 : ($urandom_range(0, 3) != 0);
         applyStimulus(cur, tk, $urandom_range(0, 299) != 0);
      end

      repeat (5) applyStimulus(cur, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      #2;
      checkValue("scoreboard_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
